// File: rtl/sprite_blitter.sv
// Sprite/clear blitter feeding the frame buffer write port: one 8-bit pixel per clock,
// with a transparent colour key and clipping at the right and bottom edges of the screen.
`timescale 1ns/1ps
module sprite_blitter #(
  parameter int         SCREEN_W    = 640,
  parameter int         SCREEN_H    = 480,
  parameter logic [7:0] TRANSPARENT = 8'hFF,
  parameter int         ROM_AW      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [9:0]        cmd_x,
  input  logic [9:0]        cmd_y,
  input  logic [6:0]        cmd_w,
  input  logic [6:0]        cmd_h,
  input  logic [ROM_AW-1:0] cmd_base,
  input  logic [7:0]        cmd_fill,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [18:0]       frame_wrAddress,
  output logic [7:0]        frame_input,
  output logic              frame_we,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, CLEAR, BLIT, DRAIN, DONE} state_t;

  localparam logic [10:0] W11       = 11'(SCREEN_W);
  localparam logic [10:0] H11       = 11'(SCREEN_H);
  localparam logic [18:0] W19       = 19'(SCREEN_W);
  localparam logic [18:0] LAST_ADDR = 19'(SCREEN_W * SCREEN_H - 1);

  state_t              state_q, state_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [18:0]         wr_addr_q, wr_addr_d;
  logic [18:0]         row_base_q, row_base_d;
  logic [9:0]          x0_q, x0_d;
  logic [6:0]          w_last_q, w_last_d;
  logic [6:0]          h_last_q, h_last_d;
  logic [6:0]          col_q, col_d;
  logic [6:0]          row_q, row_d;
  logic [10:0]         cur_x_q, cur_x_d;
  logic [10:0]         cur_y_q, cur_y_d;
  logic [7:0]          fill_q, fill_d;
  logic                clr_we_q, clr_we_d;
  logic                pend_q, pend_d;
  logic                vis_q, vis_d;
  logic                done_q, done_d;

  // y*SCREEN_W as a sum of constant shifts; for 640 this is (y<<9)+(y<<7).
  function automatic logic [18:0] times_w(input logic [9:0] y);
    logic [18:0] acc;
    acc = '0;
    for (int b = 0; b < 19; b++)
      if (SCREEN_W[b]) acc = acc + (19'(y) << b);
    return acc;
  endfunction

  always_comb begin
    // NOTE: every _d starts from its _q (or idle value) so no path through the case infers a latch.
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    wr_addr_d  = wr_addr_q;
    row_base_d = row_base_q;
    x0_d       = x0_q;
    w_last_d   = w_last_q;
    h_last_d   = h_last_q;
    col_d      = col_q;
    row_d      = row_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    fill_d     = fill_q;
    vis_d      = vis_q;
    clr_we_d   = 1'b0;
    pend_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x0_d       = cmd_x;
          w_last_d   = cmd_w - 7'd1;
          h_last_d   = cmd_h - 7'd1;
          col_d      = '0;
          row_d      = '0;
          cur_x_d    = {1'b0, cmd_x};
          cur_y_d    = {1'b0, cmd_y};
          row_base_d = times_w(cmd_y);
          fill_d     = cmd_fill;
          if (cmd_op == 2'd0) begin
            state_d   = CLEAR;
            clr_we_d  = 1'b1;
            wr_addr_d = '0;
          end else if (cmd_op == 2'd1 && cmd_w != 7'd0 && cmd_h != 7'd0) begin
            state_d    = BLIT;
            rom_addr_d = cmd_base;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      CLEAR: begin
        if (wr_addr_q == LAST_ADDR) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          clr_we_d  = 1'b1;
          wr_addr_d = wr_addr_q + 19'd1;
        end
      end

      BLIT: begin
        // The pixel addressed now is written next cycle, when its ROM byte arrives.
        pend_d     = 1'b1;
        vis_d      = (cur_x_q < W11) && (cur_y_q < H11);
        wr_addr_d  = row_base_q + 19'(cur_x_q);
        rom_addr_d = rom_addr_q + 1'b1;
        if (col_q == w_last_q) begin
          col_d   = '0;
          cur_x_d = {1'b0, x0_q};
          if (row_q == h_last_q) begin
            state_d = DRAIN;
          end else begin
            row_d      = row_q + 7'd1;
            cur_y_d    = cur_y_q + 11'd1;
            row_base_d = row_base_q + W19;
          end
        end else begin
          col_d   = col_q + 7'd1;
          cur_x_d = cur_x_q + 11'd1;
        end
      end

      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: state uses non-blocking assignments so every flop sees pre-edge values; reset is synchronous.
    if (Reset) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      wr_addr_q  <= '0;
      row_base_q <= '0;
      x0_q       <= '0;
      w_last_q   <= '0;
      h_last_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      fill_q     <= '0;
      clr_we_q   <= 1'b0;
      pend_q     <= 1'b0;
      vis_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      wr_addr_q  <= wr_addr_d;
      row_base_q <= row_base_d;
      x0_q       <= x0_d;
      w_last_q   <= w_last_d;
      h_last_q   <= h_last_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      fill_q     <= fill_d;
      clr_we_q   <= clr_we_d;
      pend_q     <= pend_d;
      vis_q      <= vis_d;
      done_q     <= done_d;
    end
  end

  // ROM data lands in the write cycle itself, so the colour key acts on it directly.
  assign frame_we        = clr_we_q | (pend_q & vis_q & (rom_data != TRANSPARENT));
  assign frame_input     = pend_q ? rom_data : (clr_we_q ? fill_q : 8'h00);
  assign frame_wrAddress = wr_addr_q;
  assign rom_addr        = rom_addr_q;
  assign cmd_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign done            = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: expected writes and ROM addresses are queued when a
// command is issued and compared as the DUT produces them. Screen height is reduced to keep clears short.
`timescale 1ns/1ps
module tb_sprite_blitter;

  localparam int W = 640;
  localparam int H = 40;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [9:0]  cmd_x = '0, cmd_y = '0;
  logic [6:0]  cmd_w = '0, cmd_h = '0;
  logic [15:0] cmd_base = '0;
  logic [7:0]  cmd_fill = '0;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [18:0] frame_wrAddress;
  logic [7:0]  frame_input;
  logic        frame_we, busy, done;

  sprite_blitter #(.SCREEN_W(W), .SCREEN_H(H), .TRANSPARENT(8'hFF), .ROM_AW(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_base(cmd_base), .cmd_fill(cmd_fill),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .frame_wrAddress(frame_wrAddress), .frame_input(frame_input), .frame_we(frame_we),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  // Synchronous sprite ROM: data is valid the cycle after the address.
  logic [7:0] rom_mem [65536];
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  typedef struct { logic [18:0] a; logic [7:0] d; } wr_t;
  wr_t         wq[$];
  logic [15:0] rq[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic mon(input string tag);
    wr_t e;
    if (frame_we === 1'b1) begin
      if (wq.size() == 0) begin
        check({tag, "_unexpected_write"}, {13'd0, frame_wrAddress}, 32'hFFFF_FFFF);
      end else begin
        e = wq.pop_front();
        check({tag, "_wr_addr"}, {13'd0, frame_wrAddress}, {13'd0, e.a});
        check({tag, "_wr_data"}, {24'd0, frame_input}, {24'd0, e.d});
      end
    end else if (frame_we !== 1'b0) begin
      check({tag, "_we_known"}, {31'd0, frame_we}, 32'd0);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [9:0] x, input logic [9:0] y,
                       input logic [6:0] w, input logic [6:0] h, input logic [15:0] base,
                       input logic [7:0] fill);
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_base = base; cmd_fill = fill;
    cmd_valid = 1'b1;
    check("ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called while sampling cycle 1; follows the command to its done pulse and one cycle beyond.
  task automatic run(input string tag, input int exp_done, input int budget);
    int k;
    int seen;
    k = 1;
    seen = 0;
    while (k <= budget) begin
      if (rq.size() > 0) check({tag, "_rom_addr"}, {16'd0, rom_addr}, {16'd0, rq.pop_front()});
      mon(tag);
      if (done === 1'b1) begin
        check({tag, "_we_at_done"}, {31'd0, frame_we}, 32'd0);
        seen = 1;
        break;
      end
      tick();
      k++;
    end
    check({tag, "_done_cycle"}, seen ? k : -1, exp_done);
    check({tag, "_writes_left"}, wq.size(), 0);
    check({tag, "_rom_left"}, rq.size(), 0);
    wq.delete();
    rq.delete();
    tick();
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    int writes;
    for (int i = 0; i < 65536; i++) rom_mem[i] = 8'h00;

    // Reset values
    tick(); tick();
    Reset = 1'b0;
    check("rst_we", {31'd0, frame_we}, 32'd0);
    check("rst_addr", {13'd0, frame_wrAddress}, 32'd0);
    check("rst_input", {24'd0, frame_input}, 32'd0);
    check("rst_rom_addr", {16'd0, rom_addr}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Reset in the middle of a clear aborts it without a done pulse
    issue(2'd0, 10'd0, 10'd0, 7'd0, 7'd0, 16'h0000, 8'hAA);
    for (int i = 1; i < 1000; i++) tick();
    check("midclr_we", {31'd0, frame_we}, 32'd1);
    check("midclr_addr", {13'd0, frame_wrAddress}, 32'd999);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort_we", {31'd0, frame_we}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);
    pulses = 0;
    writes = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) pulses++;
      if (frame_we === 1'b1) writes++;
      tick();
    end
    check("abort_done_pulses", pulses, 0);
    check("abort_writes", writes, 0);

    // Full clear of the (reduced) screen
    for (int i = 0; i < W * H; i++) wq.push_back('{a: 19'(i), d: 8'h1C});
    issue(2'd0, 10'd0, 10'd0, 7'd0, 7'd0, 16'h0000, 8'h1C);
    run("clear", W * H + 1, W * H + 100);

    // 2x2 blit with one transparent pixel
    rom_mem[16'h0100] = 8'h11; rom_mem[16'h0101] = 8'hFF;
    rom_mem[16'h0102] = 8'h33; rom_mem[16'h0103] = 8'h44;
    for (int i = 0; i < 4; i++) rq.push_back(16'h0100 + 16'(i));
    wq.push_back('{a: 19'd12810, d: 8'h11});
    wq.push_back('{a: 19'd13450, d: 8'h33});
    wq.push_back('{a: 19'd13451, d: 8'h44});
    issue(2'd1, 10'd10, 10'd20, 7'd2, 7'd2, 16'h0100, 8'h00);
    run("blit", 6, 20);

    // Clipping at the bottom-right corner
    for (int i = 0; i < 8; i++) begin
      rom_mem[16'h0200 + 16'(i)] = 8'h05;
      rq.push_back(16'h0200 + 16'(i));
    end
    wq.push_back('{a: 19'((H - 1) * W + 638), d: 8'h05});
    wq.push_back('{a: 19'((H - 1) * W + 639), d: 8'h05});
    issue(2'd1, 10'd638, 10'(H - 1), 7'd4, 7'd2, 16'h0200, 8'h00);
    run("clip", 10, 30);

    // Degenerate commands
    issue(2'd1, 10'd5, 10'd5, 7'd0, 7'd3, 16'h0400, 8'h00);
    run("deg_w0", 1, 5);
    issue(2'd3, 10'd5, 10'd5, 7'd3, 7'd3, 16'h0400, 8'h00);
    run("deg_op3", 1, 5);

    // Held command while busy, then accepted back-to-back after done
    rom_mem[16'h0300] = 8'h7E;
    for (int i = 0; i < 4; i++) rq.push_back(16'h0100 + 16'(i));
    wq.push_back('{a: 19'd12810, d: 8'h11});
    wq.push_back('{a: 19'd13450, d: 8'h33});
    wq.push_back('{a: 19'd13451, d: 8'h44});
    issue(2'd1, 10'd10, 10'd20, 7'd2, 7'd2, 16'h0100, 8'h00);
    cmd_op = 2'd1; cmd_x = 10'd0; cmd_y = 10'd0; cmd_w = 7'd1; cmd_h = 7'd1; cmd_base = 16'h0300;
    cmd_valid = 1'b1;
    run("busy_hold", 6, 20);
    rq.push_back(16'h0300);
    wq.push_back('{a: 19'd0, d: 8'h7E});
    tick();
    cmd_valid = 1'b0;
    run("b2b", 3, 10);

    // ROM address wraps modulo 2^16
    rom_mem[16'hFFFF] = 8'h21;
    rom_mem[16'h0000] = 8'h22;
    rq.push_back(16'hFFFF);
    rq.push_back(16'h0000);
    wq.push_back('{a: 19'(5 * W + 100), d: 8'h21});
    wq.push_back('{a: 19'(5 * W + 101), d: 8'h22});
    issue(2'd1, 10'd100, 10'd5, 7'd2, 7'd1, 16'hFFFF, 8'h00);
    run("rom_wrap", 4, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Upstream writer for Frame_Buffer. Drives frame_input, frame_wrAddress and frame_we, which replace the constant-enabled write port.
- Takes draw commands decoded from the NIOS to_hw ports: clear screen, or copy a rectangular sprite from sprite ROM to screen position (x,y).
- Writes one 8-bit colour-index pixel per cycle into the 640x480 buffer, with transparency and edge clipping.

Parameters:
SCREEN_W, 640, pixels per row; also the row stride of the frame buffer address
SCREEN_H, 480, number of rows
TRANSPARENT, 8'hFF, sprite colour that is never written
ROM_AW, 16, sprite ROM address width

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  2  0=clear, 1=blit, 2/3=reserved (no-op)
cmd_x  in  10  blit left column
cmd_y  in  10  blit top row
cmd_w  in  7  sprite width, 0..127
cmd_h  in  7  sprite height, 0..127
cmd_base  in  ROM_AW  sprite ROM base address
cmd_fill  in  8  clear colour
rom_addr  out  ROM_AW  sprite ROM read address
rom_data  in  8  ROM data, valid exactly 1 cycle after rom_addr
frame_wrAddress  out  19  frame buffer write address, y*SCREEN_W+x
frame_input  out  8  frame buffer write data
frame_we  out  1  frame buffer write enable
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, active-high): state=IDLE on the next edge. frame_we=0, frame_wrAddress=0, frame_input=0, rom_addr=0, done=0, busy=0. Reset overrides any in-progress command. No done pulse is produced for an aborted command.
- States: IDLE, CLEAR, BLIT, DRAIN, DONE.
- cmd_ready = (state==IDLE). A command is accepted on an edge where cmd_valid&&cmd_ready; call this cycle 0. All cmd_* fields are latched at acceptance. cmd_valid in any other state is ignored.
- IDLE transitions on acceptance:
  - op=0 -> CLEAR.
  - op=1 with w,h nonzero -> BLIT.
  - op=1 with w==0 or h==0, or op=2/3 -> DONE.
- CLEAR:
  - Cycles 1..SCREEN_W*SCREEN_H: frame_we=1, frame_input=fill, frame_wrAddress=k-1 in cycle k.
  - After the address reaches 307199, go to DONE (cycle 307201).
- BLIT:
  - Pixels are visited row-major, j=0..h-1, i=0..w-1; N=w*h.
  - In cycle k (1..N), rom_addr = base + (k-1), wrapping modulo 2^ROM_AW.
  - In cycle k+1, the pixel fetched in cycle k is written: frame_wrAddress=(y+j)*SCREEN_W+(x+i), frame_input=rom_data.
  - frame_we=1 only if rom_data!=TRANSPARENT AND x+i<SCREEN_W AND y+j<SCREEN_H. Sums use 11-bit arithmetic, so there is no wrap onto the opposite edge.
  - Clipped and transparent pixels still consume a cycle, with frame_we=0.
  - After the last address (cycle N), go to DRAIN (cycle N+1, final write), then DONE (cycle N+2).
- Address generation: no multiplier. Keep a running row-base register, loaded with y*640 computed as (y<<9)+(y<<7), plus SCREEN_W per row; add the column counter.
- DONE: done=1 and frame_we=0 for one cycle, then IDLE. cmd_ready is 0 during DONE, so the earliest next accept is the cycle after done.
- frame_we=0 in IDLE, DONE and every non-write cycle.
- Throughput is 1 pixel/clock. Total latency is N+2 cycles for a blit and 307201 cycles for a clear.

Test Plan:
- Reset: assert Reset mid-CLEAR at cycle 1000 -> next cycle frame_we=0, busy=0, cmd_ready=1, done never pulses; a new command is accepted afterwards.
- Clear, fill=8'h1C -> exactly 307200 writes, first addr 0, last addr 307199, all data 8'h1C; done=1 at cycle 307201 only.
- Blit at (10,20), w=2, h=2, base=16'h0100, ROM[100..103]={11,FF,33,44}:
  - rom_addr 100..103 in cycles 1..4.
  - Writes: 12810<-11 (cycle 2), 13450<-33 (cycle 4), 13451<-44 (cycle 5).
  - Cycle 3: frame_we=0.
  - done at cycle 6.
- Clip: blit at (638,479), w=4, h=2, all ROM data 8'h05 -> only 307198 and 307199 written; 8 ROM reads; done at cycle 10.
- Degenerate: op=1 with w=0, and separately op=3 -> no writes, no ROM sweep, done at cycle 1, cmd_ready back at cycle 2.
- Busy: hold cmd_valid=1 with a blit command during a blit -> no second acceptance until IDLE. A back-to-back command accepted the cycle after done runs correctly. ROM wrap: base=FFFF, w=2, h=1 -> rom_addr FFFF then 0000.
